// File: rtl/arb2_pkg.sv
// arb2_pkg: shared state and grant encodings for the two-requester packet arbiter
package arb2_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;
endpackage

// File: rtl/arb2_sel.sv
// arb2_sel: vector 2:1 selector, forced to zero when not enabled
module arb2_sel #(
  parameter int W = 10
) (
  input  logic         sel,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = !en ? '0 : (sel ? b : a);
endmodule

// File: rtl/arb2_mux_ctrl.sv
// arb2_mux_ctrl: round-robin packet arbiter driving the select of a shared 2:1 stream mux
module arb2_mux_ctrl
  import arb2_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [1:0]    grant,
  output logic          sel
);
  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   sel_q, sel_d;
  logic   cur, own_v, own_l, oth_v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
    end
  end
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cur     = state_q == OWN1;
    own_v   = cur ? s1_valid : s0_valid;
    own_l   = cur ? s1_last  : s0_last;
    oth_v   = cur ? s0_valid : s1_valid;
    if (state_q == IDLE) begin
      if (s0_valid && (!s1_valid || !prio_q))
        state_d = OWN0;
      else if (s1_valid)
        state_d = OWN1;
    end else if (own_v && m_ready && own_l) begin
      // packet end hands priority over; a waiting peer takes the bus with no bubble
      prio_d  = !cur;
      state_d = !oth_v ? IDLE : (cur ? OWN0 : OWN1);
    end
    sel_d = state_d == OWN1 ? 1'b1 : (state_d == OWN0 ? 1'b0 : sel_q);
  end
  assign sel      = sel_q;
  assign s0_ready = (state_q == OWN0) && m_ready;
  assign s1_ready = (state_q == OWN1) && m_ready;
  assign grant    = state_q == OWN0 ? GNT_0 : (state_q == OWN1 ? GNT_1 : GNT_NONE);
  arb2_sel #(.W(DW + 2)) u_sel (
    .sel (sel_q),
    .en  (state_q != IDLE),
    .a   ({s0_valid, s0_last, s0_data}),
    .b   ({s1_valid, s1_last, s1_data}),
    .y   ({m_valid, m_last, m_data})
  );
endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// tb_arb2_mux_ctrl: directed vectors with hand-computed expectations for arb2_mux_ctrl
module tb_arb2_mux_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic       m_valid, m_last, m_ready;
  logic [7:0] m_data;
  logic [1:0] grant;
  logic       sel;
  int         n_vec = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  arb2_mux_ctrl #(.DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .grant    (grant),
    .sel      (sel)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic mv, input logic [7:0] md, input logic ml,
                            input logic [1:0] g, input logic r0, input logic r1);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
    chk({tag, ".m_data"}, 32'(m_data), 32'(md));
    chk({tag, ".m_last"}, 32'(m_last), 32'(ml));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".s0_ready"}, 32'(s0_ready), 32'(r0));
    chk({tag, ".s1_ready"}, 32'(s1_ready), 32'(r1));
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  logic [7:0] bp_data [5] = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h12};
  logic       bp_rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       bp_last [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b1; s0_data = 8'h00; s0_last = 1'b0;
    s1_valid = 1'b1; s1_data = 8'h10; s1_last = 1'b0;
    m_ready = 1'b1;
    #12;
    expect_out("rst", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("rst.sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.grant", 32'(grant), 32'd0);
    cyc;
    for (int i = 0; i < 3; i++) begin
      s0_data = 8'(i);
      s0_last = (i == 2);
      #1;
      expect_out("cont_s0", 1'b1, 8'(i), i == 2, 2'b01, 1'b1, 1'b0);
      chk("cont_s0.sel", 32'(sel), 32'd0);
      cyc;
    end
    s0_data = 8'hA0;
    s0_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s1_data = bp_data[i];
      s1_last = bp_last[i];
      m_ready = bp_rdy[i];
      #1;
      expect_out("bp_s1", 1'b1, bp_data[i], bp_last[i], 2'b10, 1'b0, bp_rdy[i]);
      chk("bp_s1.sel", 32'(sel), 32'd1);
      cyc;
    end
    m_ready = 1'b1;
    s1_last = 1'b1;
    for (int n = 0; n < 8; n++) begin
      s0_data = 8'hA0 + 8'(n / 2);
      s1_data = 8'hB0 + 8'(n / 2);
      #1;
      expect_out("fair", 1'b1, (n % 2) ? 8'hB0 + 8'(n / 2) : 8'hA0 + 8'(n / 2), 1'b1,
                 (n % 2) ? 2'b10 : 2'b01, !(n % 2), (n % 2) == 1);
      cyc;
    end
    s1_valid = 1'b0;
    s0_data = 8'h55;
    #1;
    expect_out("idle_a", 1'b1, 8'h55, 1'b1, 2'b01, 1'b1, 1'b0);
    cyc;
    s0_data = 8'h66;
    #1;
    expect_out("idle_gap", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc;
    expect_out("idle_b", 1'b1, 8'h66, 1'b1, 2'b01, 1'b1, 1'b0);
    cyc;
    s0_valid = 1'b0;
    s1_valid = 1'b1; s1_data = 8'h20; s1_last = 1'b0;
    #1;
    expect_out("mid_idle", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc;
    for (int i = 0; i < 2; i++) begin
      s1_data = 8'h20 + 8'(i);
      #1;
      expect_out("mid_s1", 1'b1, 8'h20 + 8'(i), 1'b0, 2'b10, 1'b0, 1'b1);
      cyc;
    end
    s1_data = 8'h22;
    s0_valid = 1'b1; s0_data = 8'h30; s0_last = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("rst_mid", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("rst_mid.sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
    cyc;
    expect_out("post_rst", 1'b1, 8'h30, 1'b1, 2'b01, 1'b1, 1'b0);
    cyc;
    s0_valid = 1'b0;
    s1_data = 8'h40; s1_last = 1'b1;
    #1;
    expect_out("s1_one", 1'b1, 8'h40, 1'b1, 2'b10, 1'b0, 1'b1);
    cyc;
    s1_valid = 1'b0;
    #1;
    expect_out("s1_idle", 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("sel_hold", 32'(sel), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arb2_mux_ctrl.md
# arb2_mux_ctrl

Two-requester round-robin arbiter and sequencer for the shared 2:1 datapath mux. It owns the select line of a DW-wide 2:1 selector. It grants whole packets (valid/ready/last streams) from two sources onto one sink. Packets are never interleaved, and each completed packet passes priority to the other requester. It sits between two producer stages and a single downstream consumer.

## Interface
Parameters:
- DW, 8, data width of each stream.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_valid  in  1  requester 0 beat valid.
- s0_data  in  DW  requester 0 beat data.
- s0_last  in  1  requester 0 final beat of packet.
- s0_ready  out  1  requester 0 beat accepted.
- s1_valid / s1_data / s1_last / s1_ready: same as s0, for requester 1.
- m_valid  out  1  sink beat valid.
- m_data  out  DW  sink beat data.
- m_last  out  1  sink final beat.
- m_ready  in  1  sink accepts beat.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- sel  out  1  mux select: 1 = requester 1, 0 = requester 0; holds last owner when idle.

Reset is asynchronous and active-low. The clock is clk and the reset is rst_n.

## Operation
- State machine states: IDLE, OWN0, OWN1. Priority pointer prio is 1 bit; 0 means requester 0 is preferred.
- Handshake: a beat transfers when the owner's valid and m_ready are both 1 in the same cycle.
- IDLE:
  - outputs m_valid=0, s0_ready=0, s1_ready=0, grant=00.
  - If only s0_valid is 1, go to OWN0. If only s1_valid is 1, go to OWN1.
  - If both are 1, go to OWN[prio].
  - If neither is 1, stay in IDLE.
- OWNx, combinational pass-through:
  - m_valid=sx_valid, m_data=sx_data, m_last=sx_last.
  - sx_ready=m_ready; the other requester's ready is 0.
  - grant=onehot(x), sel=x.
- Packet end (handshake with sx_last=1 while in OWNx):
  - prio is set to the other requester (~x).
  - If the other requester's valid is 1 in that cycle, go directly to OWN(~x), with no bubble.
  - Otherwise go to IDLE.
- Mid-packet: ownership is held regardless of the other requester's valid, and for any number of stall cycles while sx_valid=0 or m_ready=0.
- A single-beat packet (valid and last together) ends ownership in one cycle.
- The data path is purely combinational through the mux. The controller adds no data storage.
- Reset mid-packet: ownership is dropped immediately and state returns to IDLE with prio=0. Requesters must restart their packets. The requester-side protocol is outside this block.

## Timing
- Reset values:
  - state=IDLE, prio=0, sel=0, grant=00.
  - m_valid=0, s0_ready=0, s1_ready=0, m_last=0.
  - m_data=0 while idle.
- Grant latency from IDLE: 1 cycle. Valid seen in cycle N gives grant and pass-through in cycle N+1.
- During ownership, sink-to-source latency is 0 cycles (ready→ready, valid→valid, both combinational).
- Back-to-back packets across requesters have 0 idle cycles.
- A new packet from the same requester when the other is not waiting goes through IDLE, which costs 1 cycle.
- Simultaneous first request from both after reset: requester 0 wins.
- The other requester's ready must never be 1 in the same cycle as the owner's ready.

## Structure
- Shared package arb2_pkg holds:
  - typedef of the 3-state enum (IDLE, OWN0, OWN1).
  - localparams for the grant encodings (GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10).
- One sub-module, arb2_sel: a vector 2:1 selector of width DW+2 over {valid,last,data}, driven by sel. It is gated to 0 when idle.
- The FSM, prio register and ready steering live in the top module.

## Test plan
- Reset: assert rst_n=0 with both valids at 1 → all outputs zero and grant=00. Release → one cycle later grant=01 (requester 0 wins).
- Contention: both requesters send 3-beat packets with m_ready=1 → sink sees s0 beats 0–2, then s1 beats 0–2 with no gap, and grant goes 01→10.
- Backpressure: m_ready toggles 1,0,0,1 mid-packet of s1 while s0_valid=1 → s0_ready stays 0, no s0 beat appears before s1 last, and m_data holds stable while stalled.
- Fairness: both valid continuously with 1-beat packets (data 0xA0.., 0xB0..) → sink alternates A,B,A,B for 8 beats.
- Idle path: s0 sends 1-beat packet 0x55, s1 idle, then s0 sends 0x66 → exactly one IDLE cycle between the two packets, and grant goes 01→00→01.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 4-beat s1 packet → grant=00, prio=0, and m_valid=0 immediately (asynchronous).
